clawgame_sequencer: RTL and testbench

Game-level sequencer for the claw machine: owns the idle/ready/play/over state machine, the one-second countdown, and the score counter, and produces the `game_active` enable sent to the Arduino. It sits between the board inputs (start button, Arduino score pulse) and the LED display controller, replacing free-running timer and score logic with one coordinated controller. All outputs are registered.

---
 rtl/clawgame_sequencer.sv | 164 ++++++++++++++++
 tb/tb_clawgame_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clawgame_sequencer.sv
// Claw machine game sequencer: IDLE/READY/PLAY/OVER control, one-second countdown and score.
// Optional high-score register enabled by defining CLAWGAME_HIGH_SCORE_EN.
module clawgame_sequencer #(
  parameter int CLK_HZ          = 100000000,
  parameter int GAME_SECONDS    = 60,
  parameter int READY_SECONDS   = 3,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        increment_score,
  output logic [1:0]  state,
  output logic        game_active,
  output logic [15:0] time_left,
  output logic [15:0] score,
  output logic        game_over
`ifdef CLAWGAME_HIGH_SCORE_EN
  ,
  output logic [15:0] high_score
`endif
);

  localparam int TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t state_q, state_next;

  logic          start_meta, start_sync, start_level, start_prev, start_evt;
  logic [DW-1:0] deb_cnt;
  logic          inc_meta, inc_sync, inc_prev, score_evt;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [15:0]   time_next, score_next;
  logic          ending;

  // Both inputs are asynchronous; start is also debounced because it is a mechanical switch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      start_meta  <= 1'b0;
      start_sync  <= 1'b0;
      start_level <= 1'b0;
      start_prev  <= 1'b0;
      start_evt   <= 1'b0;
      deb_cnt     <= '0;
      inc_meta    <= 1'b0;
      inc_sync    <= 1'b0;
      inc_prev    <= 1'b0;
      score_evt   <= 1'b0;
    end else begin
      start_meta <= start_btn;
      start_sync <= start_meta;
      if (start_sync == start_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        start_level <= start_sync;
        deb_cnt     <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
      start_prev <= start_level;
      start_evt  <= start_level & ~start_prev;
      inc_meta   <= increment_score;
      inc_sync   <= inc_meta;
      inc_prev   <= inc_sync;
      score_evt  <= inc_sync & ~inc_prev;
    end
  end

  assign tick = (tick_cnt == TW'(CLK_HZ - 1));

  // Restarting the second on every transition keeps each phase an exact number of seconds.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if ((state_next != state_q) || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state_q;
    time_next  = time_left;
    score_next = score;
    case (state_q)
      IDLE, OVER: begin
        time_next = 16'd0;
        if (start_evt) begin
          state_next = READY;
          time_next  = 16'(READY_SECONDS);
          score_next = 16'd0;
        end
      end
      READY: begin
        if (tick) begin
          // A zero-length READY still waits one full tick before PLAY.
          if (time_left <= 16'd1) begin
            state_next = PLAY;
            time_next  = 16'(GAME_SECONDS);
          end else begin
            time_next = time_left - 16'd1;
          end
        end
      end
      PLAY: begin
        if (score_evt && (score != 16'hFFFF)) begin
          score_next = score + 16'd1;
        end
        if (tick) begin
          if (time_left <= 16'd1) begin
            state_next = OVER;
            time_next  = 16'd0;
          end else begin
            time_next = time_left - 16'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ending = (state_q == PLAY) && (state_next == OVER);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      time_left   <= 16'd0;
      score       <= 16'd0;
      game_active <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state_q     <= state_next;
      time_left   <= time_next;
      score       <= score_next;
      game_active <= (state_next == PLAY);
      game_over   <= ending;
    end
  end

  assign state = state_q;

`ifdef CLAWGAME_HIGH_SCORE_EN
  // Compare against score_next so a point landing on the final tick is included.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      high_score <= 16'd0;
    end else if (ending && (score_next > high_score)) begin
      high_score <= score_next;
    end
  end
`else
  // Without the feature there is no best-score storage at all.
`endif

endmodule

// File: tb/tb_clawgame_sequencer.sv
// Randomized self-checking bench for clawgame_sequencer against a cycle-indexed game model.
// Build with CLAWGAME_HIGH_SCORE_EN defined to also check high_score.
module tb_clawgame_sequencer;

  localparam int CLK_HZ    = 10;
  localparam int GAME_S    = 5;
  localparam int READY_S   = 2;
  localparam int DEB       = 4;
  localparam int START_LAT = 2 + DEB + 1 + 1;
  localparam int SCORE_LAT = 4;
  localparam int RDY_LEN   = ((READY_S == 0) ? 1 : READY_S) * CLK_HZ;
  localparam int PLAY_LEN  = GAME_S * CLK_HZ;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_btn = 1'b0;
  logic        increment_score = 1'b0;
  logic [1:0]  state;
  logic        game_active;
  logic [15:0] time_left;
  logic [15:0] score;
  logic        game_over;
`ifdef CLAWGAME_HIGH_SCORE_EN
  logic [15:0] high_score;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit m_started = 1'b0;
  int c0 = 0;
  int m_score = 0;
  int m_high = 0;
  int exp_state = 0;
  int exp_time = 0;
  int exp_active = 0;
  int exp_over = 0;
  int press_q[$];
  int pulse_q[$];

  clawgame_sequencer #(
    .CLK_HZ(CLK_HZ),
    .GAME_SECONDS(GAME_S),
    .READY_SECONDS(READY_S),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start_btn(start_btn),
    .increment_score(increment_score),
    .state(state),
    .game_active(game_active),
    .time_left(time_left),
    .score(score),
    .game_over(game_over)
`ifdef CLAWGAME_HIGH_SCORE_EN
    ,
    .high_score(high_score)
`endif
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h at cycle %0d", tag, observed, expected, cyc);
    end
  endtask

  // Game phase as a pure function of edges elapsed since the game was started.
  function automatic int phase(input int n);
    int e;
    if (!m_started) return 0;
    e = n - c0;
    if (e < RDY_LEN) return 1;
    if (e < RDY_LEN + PLAY_LEN) return 2;
    return 3;
  endfunction

  task automatic modelStep(input int n);
    int prev, cur, e;
    prev = phase(n - 1);
    while (pulse_q.size() > 0 && pulse_q[0] + SCORE_LAT <= n) begin
      if (pulse_q[0] + SCORE_LAT == n && prev == 2 && m_score < 65535) m_score++;
      void'(pulse_q.pop_front());
    end
    while (press_q.size() > 0 && press_q[0] + START_LAT <= n) begin
      if (press_q[0] + START_LAT == n && (prev == 0 || prev == 3)) begin
        m_started = 1'b1;
        c0 = n;
        m_score = 0;
      end
      void'(press_q.pop_front());
    end
    cur = phase(n);
    e = n - c0;
    if (prev == 2 && cur == 3 && m_score > m_high) m_high = m_score;
    exp_state  = cur;
    exp_active = (cur == 2) ? 1 : 0;
    exp_over   = (cur == 3 && e == RDY_LEN + PLAY_LEN) ? 1 : 0;
    case (cur)
      1:       exp_time = READY_S - e / CLK_HZ;
      2:       exp_time = GAME_S - (e - RDY_LEN) / CLK_HZ;
      default: exp_time = 0;
    endcase
  endtask

  always @(posedge clock) begin
    if (reset) begin
      cyc++;
      modelStep(cyc);
      #1;
      if (reset) begin
        checkOutput("state", 32'(state), exp_state);
        checkOutput("time_left", 32'(time_left), exp_time);
        checkOutput("score", 32'(score), m_score);
        checkOutput("game_active", 32'(game_active), exp_active);
        checkOutput("game_over", 32'(game_over), exp_over);
`ifdef CLAWGAME_HIGH_SCORE_EN
        checkOutput("high_score", 32'(high_score), m_high);
`endif
      end
    end
  end

  // Drives one pulse on start_btn or increment_score; presses long enough to pass the debouncer are logged.
  task automatic applyStimulus(input bit is_start, input int high_cycles, input int low_cycles);
    @(negedge clock);
    if (is_start) begin
      start_btn = 1'b1;
      if (high_cycles >= DEB) press_q.push_back(cyc);
    end else begin
      increment_score = 1'b1;
      pulse_q.push_back(cyc);
    end
    repeat (high_cycles) @(negedge clock);
    start_btn = 1'b0;
    increment_score = 1'b0;
    repeat (low_cycles) @(negedge clock);
  endtask

  task automatic waitUntil(input int target);
    int guard = 0;
    while (cyc < target && guard < 300) begin
      @(negedge clock);
      guard++;
    end
  endtask

  task automatic waitForState(input logic [1:0] s, input int budget, input string tag);
    int i = 0;
    while (state !== s && i < budget) begin
      @(negedge clock);
      i++;
    end
    checkOutput(tag, 32'(state), 32'(s));
  endtask

  task automatic startGame();
    applyStimulus(1'b1, 9, 0);
    waitForState(2'd1, 20, "enter_ready");
    checkOutput("ready_time", 32'(time_left), READY_S);
  endtask

  task automatic sendPulses(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 2 + $urandom_range(0, 1), 2 + $urandom_range(0, 1));
  endtask

  task automatic finishGame();
    waitForState(2'd3, 120, "enter_over");
    repeat (3) @(negedge clock);
  endtask

  task automatic playSimple(input int n);
    startGame();
    waitUntil(c0 + 17 + $urandom_range(0, 3));
    sendPulses(n);
    finishGame();
    checkOutput("final_score", 32'(score), n);
  endtask

  initial begin
    int hs_exp[3];
    int games[3];
    hs_exp = '{4, 4, 6};
    games  = '{4, 2, 6};

    #2 reset = 1'b0;
    #1;
    checkOutput("reset_state", 32'(state), 0);
    checkOutput("reset_score", 32'(score), 0);
    checkOutput("reset_time", 32'(time_left), 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;

    applyStimulus(1'b1, $urandom_range(1, DEB - 1), 12);
    checkOutput("glitch_idle", 32'(state), 0);

    // Scoring: READY pulses are dropped, seven PLAY pulses all count.
    startGame();
    applyStimulus(1'b0, 2, 2);
    applyStimulus(1'b0, 2, 2);
    waitForState(2'd2, 30, "enter_play");
    checkOutput("play_time", 32'(time_left), GAME_S);
    sendPulses(7);
    finishGame();
    checkOutput("score_seven", 32'(score), 7);

    // A press during PLAY must be ignored.
    startGame();
    waitUntil(c0 + 18);
    sendPulses(2);
    waitUntil(c0 + 35);
    applyStimulus(1'b1, 6, 8);
    checkOutput("press_ignored", 32'(state), 2);
    finishGame();
    checkOutput("score_two", 32'(score), 2);

    // A pulse whose score_evt coincides with the final tick is still counted.
    startGame();
    waitUntil(c0 + 18);
    sendPulses(3);
    waitUntil(c0 + 65);
    applyStimulus(1'b0, 2, 2);
    finishGame();
    checkOutput("last_tick_race", 32'(score), 4);

    // Saturation at 16'hFFFF.
    startGame();
    waitUntil(c0 + 25);
    @(negedge clock);
    force dut.score = 16'hFFFE;
    m_score = 16'hFFFE;
    #1 release dut.score;
    sendPulses(3);
    finishGame();
    checkOutput("saturated", 32'(score), 32'hFFFF);

    // Asynchronous reset in the middle of PLAY.
    startGame();
    waitUntil(c0 + 18);
    sendPulses(3);
    waitUntil(c0 + 45);
    @(negedge clock);
    #2 reset = 1'b0;
    m_started = 1'b0;
    m_score = 0;
    m_high = 0;
    press_q.delete();
    pulse_q.delete();
    #1;
    checkOutput("mid_reset_state", 32'(state), 0);
    checkOutput("mid_reset_active", 32'(game_active), 0);
    checkOutput("mid_reset_time", 32'(time_left), 0);
    checkOutput("mid_reset_score", 32'(score), 0);
    checkOutput("mid_reset_over", 32'(game_over), 0);
`ifdef CLAWGAME_HIGH_SCORE_EN
    checkOutput("mid_reset_high", 32'(high_score), 0);
`endif
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (15) @(negedge clock);
    checkOutput("idle_after_reset", 32'(state), 0);

    for (int g = 0; g < 3; g++) begin
      playSimple(games[g]);
`ifdef CLAWGAME_HIGH_SCORE_EN
      checkOutput("high_after_game", 32'(high_score), hs_exp[g]);
`else
      checkOutput("no_high_game", 32'(score), hs_exp[g] - hs_exp[g] + games[g]);
`endif
    end

    repeat (5) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
